// File: rtl/cycle_seq.sv
// Bus-cycle sequencer for the 6502 core: fetch/decode/effective-address/data cycles.
// Optional `CYCLE_SEQ_RDY_EN` builds the rdy read-cycle stall; undefined, rdy is ignored.
module cycle_seq #(
   parameter int unsigned ST_W = 5
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            rdy,
   input  logic [ST_W-1:0] initial_state,
   input  logic            single_byte,
   input  logic            read,
   input  logic            load,
   input  logic            store,
   input  logic            rmw,
   input  logic            page_cross,
   output logic [ST_W-1:0] state,
   output logic            sync,
   output logic            rw,
   output logic [1:0]      addr_sel,
   output logic            pc_inc,
   output logic            ir_ld,
   output logic            adl_ld,
   output logic            adh_ld,
   output logic            ptr_ld,
   output logic            adl_idx,
   output logic            ptr_idx,
   output logic            ptr_inc,
   output logic            adh_fix,
   output logic            reg_we,
   output logic            jam
);

   typedef enum logic [4:0] {
      FETCH     = 5'h00,
      DECODE    = 5'h01,
      ZIDX      = 5'h08,
      AHI       = 5'h09,
      FIX       = 5'h0A,
      XIDX      = 5'h0B,
      PLO       = 5'h0C,
      XPHI      = 5'h0D,
      YPHI      = 5'h0E,
      DATA      = 5'h10,
      RMW_DUMMY = 5'h11,
      RMW_WR    = 5'h12,
      EXEC      = 5'h13,
      JAM       = 5'h1F
   } state_t;

   state_t     r_state, w_next;
   // r_idx: indexed flavour of the current mode (ABS,X/Y vs ABS; (ind),Y vs (ind,X))
   logic       r_idx, w_idx_next;
   logic       r_ea_abs, w_ea_next;
   logic       r_pcross;
   logic       w_go;
   logic       w_rw, w_sync, w_jam;
   logic [1:0] w_addr_sel, w_ea_sel;
   logic       w_pc_inc, w_ir_ld, w_adl_ld, w_adh_ld, w_ptr_ld;
   logic       w_adl_idx, w_ptr_idx, w_ptr_inc, w_adh_fix, w_reg_we;
   logic       w_unused_in;

   assign w_unused_in = read ^ load;
   assign w_ea_sel    = r_ea_abs ? 2'd2 : 2'd1;

   always_comb begin
      w_next     = r_state;
      w_idx_next = r_idx;
      w_ea_next  = r_ea_abs;
      w_rw       = 1'b1;
      w_sync     = 1'b0;
      w_jam      = 1'b0;
      w_addr_sel = 2'd0;
      w_pc_inc   = 1'b0;
      w_ir_ld    = 1'b0;
      w_adl_ld   = 1'b0;
      w_adh_ld   = 1'b0;
      w_ptr_ld   = 1'b0;
      w_adl_idx  = 1'b0;
      w_ptr_idx  = 1'b0;
      w_ptr_inc  = 1'b0;
      w_adh_fix  = 1'b0;
      w_reg_we   = 1'b0;
      case (r_state)
         FETCH: begin
            w_sync   = 1'b1;
            w_ir_ld  = 1'b1;
            w_pc_inc = 1'b1;
            w_next   = DECODE;
         end
         DECODE: begin
            w_adl_ld = 1'b1;
            w_ptr_ld = 1'b1;
            w_pc_inc = ~single_byte;
            case (initial_state)
               ST_W'(0): w_next = EXEC;
               ST_W'(2): begin w_next = DATA; w_ea_next = 1'b0; end
               ST_W'(3): w_next = ZIDX;
               ST_W'(4): begin w_next = AHI;  w_idx_next = 1'b0; end
               ST_W'(5): begin w_next = AHI;  w_idx_next = 1'b1; end
               ST_W'(6): begin w_next = XIDX; w_idx_next = 1'b0; end
               ST_W'(7): begin w_next = PLO;  w_idx_next = 1'b1; end
               default:  w_next = JAM;
            endcase
         end
         ZIDX: begin
            w_addr_sel = 2'd1;
            w_adl_idx  = 1'b1;
            w_next     = DATA;
            w_ea_next  = 1'b0;
         end
         AHI, YPHI: begin
            // Both fetch the high byte; indexed forms may need the FIX cycle.
            w_addr_sel = (r_state == YPHI) ? 2'd3 : 2'd0;
            w_adh_ld   = 1'b1;
            w_pc_inc   = (r_state == AHI);
            w_ea_next  = 1'b1;
            w_next     = DATA;
            if (r_idx) begin
               w_adl_idx = 1'b1;
               if (page_cross | store | rmw) w_next = FIX;
            end
         end
         FIX: begin
            w_addr_sel = 2'd2;
            w_adh_fix  = r_pcross;
            w_ea_next  = 1'b1;
            w_next     = DATA;
         end
         XIDX: begin
            w_addr_sel = 2'd3;
            w_ptr_idx  = 1'b1;
            w_next     = PLO;
         end
         PLO: begin
            w_addr_sel = 2'd3;
            w_adl_ld   = 1'b1;
            w_ptr_inc  = 1'b1;
            w_next     = r_idx ? YPHI : XPHI;
         end
         XPHI: begin
            w_addr_sel = 2'd3;
            w_adh_ld   = 1'b1;
            w_ea_next  = 1'b1;
            w_next     = DATA;
         end
         DATA: begin
            w_addr_sel = w_ea_sel;
            if (rmw) begin
               w_next = RMW_DUMMY;
            end else begin
               w_rw     = ~store;
               w_reg_we = 1'b1;
               w_next   = FETCH;
            end
         end
         RMW_DUMMY: begin
            w_addr_sel = w_ea_sel;
            w_rw       = 1'b0;
            w_next     = RMW_WR;
         end
         RMW_WR: begin
            w_addr_sel = w_ea_sel;
            w_rw       = 1'b0;
            w_reg_we   = 1'b1;
            w_next     = FETCH;
         end
         EXEC: begin
            w_reg_we = 1'b1;
            w_next   = FETCH;
         end
         JAM: begin
            w_jam  = 1'b1;
            w_next = JAM;
         end
         default: w_next = JAM;
      endcase
   end

`ifdef CYCLE_SEQ_RDY_EN
   assign w_go = rdy | ~w_rw;
`else
   logic w_unused_rdy;
   assign w_unused_rdy = rdy;
   assign w_go         = 1'b1;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= FETCH;
         r_idx    <= 1'b0;
         r_ea_abs <= 1'b0;
         r_pcross <= 1'b0;
      end else if (w_go) begin
         r_state  <= w_next;
         r_idx    <= w_idx_next;
         r_ea_abs <= w_ea_next;
         if (w_adl_idx) r_pcross <= page_cross;
      end
   end

   assign state    = ST_W'(r_state);
   assign sync     = w_sync;
   assign rw       = w_rw;
   assign addr_sel = w_addr_sel;
   assign jam      = w_jam;
   assign pc_inc   = w_pc_inc  & w_go;
   assign ir_ld    = w_ir_ld   & w_go;
   assign adl_ld   = w_adl_ld  & w_go;
   assign adh_ld   = w_adh_ld  & w_go;
   assign ptr_ld   = w_ptr_ld  & w_go;
   assign adl_idx  = w_adl_idx & w_go;
   assign ptr_idx  = w_ptr_idx & w_go;
   assign ptr_inc  = w_ptr_inc & w_go;
   assign adh_fix  = w_adh_fix & w_go;
   assign reg_we   = w_reg_we  & w_go;

endmodule

// File: doc/cycle_seq.md
# cycle_seq

Bus-cycle sequencer for the 6502 core. Takes the opcode-decoder outputs (initial addressing state, access pattern, single-byte flag) and steps the machine through fetch, decode, effective-address and data cycles. It drives the address-source select, R/W, PC increment and address-latch strobes, and generates the result-commit strobe. Sits between the decoder and the address/datapath registers (PC, ADL, ADH, BAL pointer).

## Interface
- `ST_W`, default 5: state / initial_state width.
- `i_clk` in 1: clock.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `rdy` in 1: bus ready. Low stalls read cycles.
- `initial_state` in ST_W: decoder start state, combinational from IR.
- `single_byte` in 1: opcode has no operand byte.
- `read`, `load`, `store`, `rmw` in 1 each: decoder access pattern, registered one cycle after IR load.
- `page_cross` in 1: carry out of ADL+index, valid in any cycle asserting `adl_idx`.
- `state` out ST_W: current state.
- `sync` out 1: opcode fetch cycle.
- `rw` out 1: 1 = read, 0 = write.
- `addr_sel` out 2: 0 = PC, 1 = {00,ADL}, 2 = {ADH,ADL}, 3 = {00,BAL}.
- `pc_inc`, `ir_ld`, `adl_ld`, `adh_ld`, `ptr_ld` out 1: latch/increment strobes. The `_ld` strobes load from the data bus.
- `adl_idx`, `ptr_idx` out 1: ADL/BAL += index. BAL wraps in zero page.
- `ptr_inc` out 1: BAL += 1, zero-page wrap.
- `adh_fix` out 1: ADH += 1.
- `reg_we` out 1: commit decoder result to register/flags.
- `jam` out 1: halted.

## Operation
- **initial_state codes:**
  - T0_FETCH=0x00 (imm/impl), T2_ZPG=0x02, T2_ZPGXY=0x03, T2_ABS=0x04, T2_ABSXY=0x05, T2_XIND=0x06, T2_INDY=0x07.
  - Any other code (T_JAM=0x1F, stack, JMP, branch) goes to JAM.
- **State encodings:** FETCH=0x00, DECODE=0x01, ZIDX=0x08, AHI=0x09, FIX=0x0A, XIDX=0x0B, PLO=0x0C, XPHI=0x0D, YPHI=0x0E, DATA=0x10, RMW_DUMMY=0x11, RMW_WR=0x12, EXEC=0x13, JAM=0x1F.
- **Per-state outputs and transitions.** Unlisted strobes are 0; `rw`=1 unless stated.
  - FETCH: sync, ir_ld, pc_inc, addr PC → DECODE.
  - DECODE: addr PC, adl_ld, ptr_ld, pc_inc=!single_byte. Next state by initial_state:
    - T0_FETCH → EXEC
    - ZPG → DATA (ea=ZP)
    - ZPGXY → ZIDX
    - ABS, ABSXY → AHI
    - XIND → XIDX
    - INDY → PLO
    - else → JAM
  - ZIDX: addr ZP dummy read; adl_idx with carry ignored (zero-page wrap, ADH stays 0) → DATA (ea=ZP).
  - AHI: addr PC, adh_ld, pc_inc.
    - ABS → DATA (ea=ABS).
    - ABSXY also asserts adl_idx → FIX if (page_cross | store | rmw), else DATA.
  - FIX: addr ABS dummy read, adh_fix = latched page_cross → DATA.
  - XIDX: addr PTR dummy read, ptr_idx → PLO.
  - PLO: addr PTR, adl_ld, ptr_inc. → XPHI for XIND, → YPHI for INDY.
  - XPHI: addr PTR, adh_ld → DATA (ea=ABS).
  - YPHI: addr PTR, adh_ld, adl_idx → FIX/DATA, same rule as AHI-ABSXY.
  - DATA: addr ea.
    - read/load: reg_we → FETCH.
    - store: rw=0, reg_we → FETCH.
    - rmw: read → RMW_DUMMY.
  - RMW_DUMMY: addr ea, rw=0 (rewrite original) → RMW_WR.
  - RMW_WR: addr ea, rw=0, reg_we → FETCH.
  - EXEC: addr PC, dummy read, reg_we → FETCH.
  - JAM: jam=1, addr PC, no strobes. Exits only via reset.
- ea (ZP or ABS) is held in an internal register set on entry to DATA.
- page_cross is latched at the edge that leaves any cycle asserting adl_idx.
- **rdy:** if rdy=0 in a cycle with rw=1:
  - state and internal registers hold;
  - pc_inc, all `_ld`, `_idx`, `_inc`, `_fix` and reg_we are forced 0;
  - sync, addr_sel and rw keep their values.
  - Write cycles (rw=0) ignore rdy.

## Timing
- Reset values: state=FETCH, sync=1, ir_ld=1, pc_inc=1, rw=1, addr_sel=0, all other outputs 0.
- Outputs are combinational from state and inputs. Transitions occur on the rising edge of i_clk.
- Asserting i_rst_n=0 mid-instruction forces FETCH immediately (asynchronously). A pending write is abandoned.
- **Cycle counts, FETCH through last cycle:**
  - imm/impl: 3
  - zpg read/store: 3; zpg rmw: 5
  - zpg,X: 4 / 6 (rmw)
  - abs read/store: 4
  - abs,X/Y: read 4 (no cross) or 5 (cross); store 5; rmw 7
  - (ind,X): 6 read
  - (ind),Y: 5 read (no cross) or 6 (cross); store 6

## Configuration
- `CYCLE_SEQ_RDY_EN`:
  - Defined: the rdy stall behaviour above is implemented.
  - Undefined: the rdy port exists but is ignored (treated as 1), and no gating logic is built.

## Test plan
- Reset asserted during RMW_DUMMY → state=0x00, rw=1, sync=1 in the same cycle. After release: FETCH, DECODE, EXEC for initial_state=0x00.
- ZPG rmw (initial_state=0x02, rmw=1) → states 00,01,10,11,12,00. rw=1,1,1,0,0. reg_we only in 0x12.
- ABSXY read, page_cross=0 at AHI → 00,01,09,10. Repeat with page_cross=1 → 00,01,09,0A,10 with adh_fix=1 in FIX. Store with page_cross=0 still visits 0A with adh_fix=0.
- INDY read, page_cross=1 → 00,01,0C,0E,0A,10. addr_sel=3 in 0C and 0E. ptr_inc=1 only in 0C.
- rdy=0 for 2 cycles during PLO (with CYCLE_SEQ_RDY_EN) → state holds at 0x0C for 3 cycles with adl_ld=0 while stalled. rdy=0 during RMW_WR → no stall.
- initial_state=0x1F → state 0x1F with jam=1 held for 10 cycles. Recovers only after i_rst_n pulse.
